// File: rtl/pwm_gen_top.sv
// Multi-phase, interleaved, multilevel PWM generator with complementary gate outputs.
// One unfolded triangle carrier per (phase, interleave) slot; one dead-time cell per level.
module pwm_gen_top #(
  parameter int unsigned PhaseCount      = 3,
  parameter int unsigned InterleaveCount = 4,
  parameter int unsigned LevelCount      = 2,
  parameter int unsigned BIT_WIDTH       = 16
) (
  input  logic                                             MClk,
  input  logic                                             RstN,
  input  logic [BIT_WIDTH-1:0]                             Compare,
  input  logic [BIT_WIDTH-1:0]                             PWMMaxCount,
  input  logic [BIT_WIDTH-1:0]                             TriangleStepSize,
  input  logic [BIT_WIDTH-1:0]                             DeadTimeCount,
  output logic [PhaseCount*InterleaveCount*LevelCount*2-1:0] S
);

  localparam int unsigned N    = PhaseCount * InterleaveCount;
  localparam int unsigned NC   = N * LevelCount;
  localparam int unsigned CW   = BIT_WIDTH + 2;
  localparam int unsigned CMPW = BIT_WIDTH + $clog2(LevelCount) + 1;
  localparam int unsigned OW   = CW + $clog2(N) + 1;

  logic [CW-1:0]        w_m;
  logic [CW-1:0]        w_2m;
  logic [CW-1:0]        w_off  [N];
  logic [CW-1:0]        w_sum  [N];
  logic [CW-1:0]        w_next [N];
  logic [CW-1:0]        w_tri  [N];
  logic [NC-1:0]        w_raw;

  logic [CW-1:0]        r_u    [N];
  logic [BIT_WIDTH-1:0] r_cnt  [NC];
  logic [NC-1:0]        r_tgt;
  logic [NC-1:0]        r_h;
  logic [NC-1:0]        r_lo;

  assign w_m  = CW'(PWMMaxCount);
  assign w_2m = {1'b0, PWMMaxCount, 1'b0};

  // Offsets track the live peak but are only loaded while reset is held.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_off[k]  = CW'((OW'(k) * OW'(w_2m)) / OW'(N));
      w_sum[k]  = r_u[k] + CW'(TriangleStepSize);
      if (w_m == '0) begin
        w_next[k] = '0;
      end else if (w_sum[k] >= w_2m) begin
        w_next[k] = w_sum[k] - w_2m;
      end else begin
        w_next[k] = w_sum[k];
      end
      w_tri[k]  = (r_u[k] < w_m) ? r_u[k] : (w_2m - r_u[k]);
    end
  end

  // Cell c = k*L + l compares against its slot carrier lifted by l*M.
  always_comb begin
    w_raw = '0;
    for (int c = 0; c < NC; c++) begin
      w_raw[c] = CMPW'(Compare) >
                 (CMPW'(w_tri[c / LevelCount]) +
                  CMPW'(c % LevelCount) * CMPW'(PWMMaxCount));
    end
  end

  always_ff @(posedge MClk) begin
    if (RstN) begin
      for (int k = 0; k < N; k++) begin
        r_u[k] <= w_off[k];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r_u[k] <= w_next[k];
      end
    end
  end

  // Dead-time: any change of the raw state blanks both switches for D+1 clocks.
  always_ff @(posedge MClk) begin
    if (RstN) begin
      r_tgt <= '0;
      r_h   <= '0;
      r_lo  <= '0;
      for (int c = 0; c < NC; c++) begin
        r_cnt[c] <= DeadTimeCount;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (w_raw[c] != r_tgt[c]) begin
          r_tgt[c] <= w_raw[c];
          r_h[c]   <= 1'b0;
          r_lo[c]  <= 1'b0;
          r_cnt[c] <= DeadTimeCount;
        end else if (r_cnt[c] != '0) begin
          r_cnt[c] <= r_cnt[c] - 1'b1;
          r_h[c]   <= 1'b0;
          r_lo[c]  <= 1'b0;
        end else begin
          r_h[c]   <= r_tgt[c];
          r_lo[c]  <= ~r_tgt[c];
        end
      end
    end
  end

  always_comb begin
    S = '0;
    for (int c = 0; c < NC; c++) begin
      S[2*c]   = r_h[c];
      S[2*c+1] = r_lo[c];
    end
  end

endmodule

// File: tb/tb_pwm_gen_top.sv
// Randomized bench for pwm_gen_top: closed-form carrier model plus timestamp dead-time model,
// checked every cycle, with literal duty/latency expectations for the nominal setup.
module tb_pwm_gen_top;

  localparam int P  = 3;
  localparam int I  = 4;
  localparam int L  = 2;
  localparam int BW = 16;
  localparam int N  = P * I;
  localparam int NC = N * L;

  logic            MClk = 1'b0;
  logic            RstN = 1'b1;
  logic [BW-1:0]   Compare = '0;
  logic [BW-1:0]   PWMMaxCount = 16'd500;
  logic [BW-1:0]   TriangleStepSize = 16'd2;
  logic [BW-1:0]   DeadTimeCount = 16'd5;
  logic [NC*2-1:0] S;

  int passed = 0;
  int total  = 0;

  pwm_gen_top #(
    .PhaseCount      (P),
    .InterleaveCount (I),
    .LevelCount      (L),
    .BIT_WIDTH       (BW)
  ) dut (
    .MClk             (MClk),
    .RstN             (RstN),
    .Compare          (Compare),
    .PWMMaxCount      (PWMMaxCount),
    .TriangleStepSize (TriangleStepSize),
    .DeadTimeCount    (DeadTimeCount),
    .S                (S)
  );

  always #5 MClk = ~MClk;

  // Model state: edges so far, edges since last reset edge, and per cell the current
  // target, the edge at which it was (re)loaded and the dead time captured then.
  longint e = 0;
  longint n = 0;
  bit     in_rst = 1'b0;
  bit     model_valid = 1'b0;
  bit     m_tgt [NC];
  longint m_t   [NC];
  longint m_d   [NC];

  function automatic longint off_of(int k, longint m);
    return (longint'(k) * 2 * m) / N;
  endfunction

  // Carrier position in closed form: offset plus elapsed steps, modulo 2M.
  function automatic longint tri_of(int k, longint cnt);
    longint m;
    longint u;
    m = longint'(PWMMaxCount);
    if (m == 0) return 0;
    u = (off_of(k, m) + cnt * longint'(TriangleStepSize)) % (2 * m);
    return (u < m) ? u : (2 * m - u);
  endfunction

  function automatic logic [NC*2-1:0] expected_s();
    logic [NC*2-1:0] v;
    bit on;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      on = !in_rst && ((e - m_t[c]) > m_d[c]);
      v[2*c]   = on && m_tgt[c];
      v[2*c+1] = on && !m_tgt[c];
    end
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, want %0d", name, act, exp);
    else passed++;
  endtask

  always @(posedge MClk) begin
    e++;
    if (RstN) begin
      n = 0;
      in_rst = 1'b1;
      model_valid = 1'b1;
      for (int c = 0; c < NC; c++) begin
        m_tgt[c] = 1'b0;
        m_t[c]   = e;
        m_d[c]   = longint'(DeadTimeCount);
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit raw;
        raw = longint'(Compare) > (tri_of(c / L, n) + longint'(c % L) * longint'(PWMMaxCount));
        if (raw != m_tgt[c]) begin
          m_tgt[c] = raw;
          m_t[c]   = e;
          m_d[c]   = longint'(DeadTimeCount);
        end
      end
      n++;
      in_rst = 1'b0;
    end
  end

  always @(negedge MClk) begin
    if (model_valid) begin
      logic [NC*2-1:0] want;
      want = expected_s();
      total++;
      if (S !== want) $display("FAIL S_vs_model t=%0t: got %h, want %h", $time, S, want);
      else passed++;
    end
  end

  int cnt_a, cnt_b, cnt_c, cnt_d;
  bit found;
  int mm;

  initial begin
    // Reset for 3 clocks with M=500, step=2, D=5.
    repeat (3) @(negedge MClk);
    check("off_k1", off_of(1, 500), 83);
    check("off_k11", off_of(11, 500), 916);
    check("reset_S", longint'(S), 0);
    RstN = 1'b0;
    cnt_a = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge MClk);
      if (S[1]) begin
        cnt_a = i;
        found = 1'b1;
      end
    end
    check("lo_rise_clocks", cnt_a, 6);
    check("all_lo_after_release", longint'(S), 48'hAAAA_AAAA_AAAA);

    // Duty checks on slot 1 (cells 2 and 3), counted over one 500-clock period.
    Compare = 16'd300;
    repeat (600) @(negedge MClk);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    repeat (500) begin
      @(negedge MClk);
      cnt_a += int'(S[4]); cnt_b += int'(S[5]); cnt_c += int'(S[6]); cnt_d += int'(S[7]);
    end
    check("c300_h0_on", cnt_a, 294);
    check("c300_lo0_on", cnt_b, 194);
    check("c300_h1_on", cnt_c, 0);
    check("c300_lo1_on", cnt_d, 500);

    Compare = 16'd150;
    repeat (600) @(negedge MClk);
    cnt_a = 0;
    repeat (500) begin
      @(negedge MClk);
      cnt_a += int'(S[4]);
    end
    check("c150_h0_on", cnt_a, 144);

    Compare = 16'd600;
    repeat (600) @(negedge MClk);
    cnt_a = 0; cnt_c = 0;
    repeat (500) begin
      @(negedge MClk);
      cnt_a += int'(S[4]); cnt_c += int'(S[6]);
    end
    check("c600_h0_on", cnt_a, 500);
    check("c600_h1_on", cnt_c, 94);

    // Reset while H is on.
    check("h0_on_before_reset", longint'(S[4]), 1);
    RstN = 1'b1;
    @(negedge MClk);
    check("midrun_reset_S", longint'(S), 0);
    repeat (2) @(negedge MClk);

    // D=0: exactly one blank clock on a change of r.
    DeadTimeCount = 16'd0;
    Compare = 16'd0;
    RstN = 1'b0;
    repeat (10) @(negedge MClk);
    Compare = 16'd1001;
    cnt_a = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge MClk);
      if (S[0]) found = 1'b1;
      else if (S[1:0] == 2'b00) cnt_a++;
    end
    check("d0_h_rises", longint'(found), 1);
    check("d0_blank_clocks", cnt_a, 1);

    // D=5: a 3-clock pulse of r is swallowed.
    DeadTimeCount = 16'd5;
    Compare = 16'd0;
    repeat (20) @(negedge MClk);
    Compare = 16'd1001;
    repeat (3) @(negedge MClk);
    Compare = 16'd0;
    cnt_a = 0;
    repeat (20) begin
      @(negedge MClk);
      cnt_a += int'(S[0]);
    end
    check("short_pulse_h_on", cnt_a, 0);

    // Randomized segments, each started by a reset with fresh M/step/D.
    for (int seg = 0; seg < 12; seg++) begin
      @(negedge MClk);
      RstN = 1'b1;
      mm = (seg == 3) ? 0 : int'($urandom_range(1, 700));
      PWMMaxCount = 16'(mm);
      TriangleStepSize = (mm == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom_range(0, 2 * mm));
      DeadTimeCount = 16'($urandom_range(0, 8));
      Compare = 16'($urandom_range(0, L * mm + 2));
      repeat ($urandom_range(1, 3)) @(negedge MClk);
      RstN = 1'b0;
      for (int cyc = 0; cyc < 700; cyc++) begin
        @(negedge MClk);
        if ($urandom_range(0, 19) == 0) Compare = 16'($urandom_range(0, L * mm + 2));
        if ($urandom_range(0, 99) == 0) DeadTimeCount = 16'($urandom_range(0, 8));
        RstN = ($urandom_range(0, 399) == 0);
      end
    end
    RstN = 1'b0;
    @(negedge MClk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
